rnn_preact_mac: RTL

Streaming multiply-accumulate stage that computes one RNN pre-activation value, sum(w[i]*x[i]) + bias over N element pairs in Q4.12 fixed point. It saturates the result to 16 bits and presents it, through a valid/ready handshake, to the combinational tanh activation stage directly downstream. One instance is used per hidden-unit lane.

---
 rtl/rnn_preact_mac.sv | 115 +++++++++++
 1 files changed

// File: rtl/rnn_preact_mac.sv
// Streaming MAC for one RNN hidden-unit lane: accumulates sum(w*x) + bias
// over N Q4.12 pairs, then saturates to Q4.12 and holds the result for the
// downstream tanh stage until it is taken.
module rnn_preact_mac #(
    parameter int N     = 16,
    parameter int ACC_W = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_w,
    input  logic [15:0] in_x,
    input  logic [15:0] in_bias,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_sat
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
    localparam logic signed [ACC_W-1:0] MAX_R = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] MIN_R = ACC_W'(-32768);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] r;
    logic [15:0]             conv_data;
    logic                    conv_sat;
    logic                    accept;
    logic                    last;

    assign accept   = in_valid && in_ready;
    assign last     = (cnt == LAST_CNT);
    assign prod     = $signed(in_w) * $signed(in_x);
    assign prod_ext = {{(ACC_W - 32){prod[31]}}, prod};
    assign bias_ext = {{(ACC_W - 28){in_bias[15]}}, in_bias, 12'h000};

    // Running sum including the current beat; bias seeds the first beat.
    always_comb begin
        sum = ((cnt == '0) ? bias_ext : acc) + prod_ext;
        r   = sum >>> 12;
    end

    // Q8.24 -> Q4.12 by truncation toward -inf with saturation to 16 bits.
    always_comb begin
        conv_data = r[15:0];
        conv_sat  = 1'b0;
        if (r > MAX_R) begin
            conv_data = 16'h7FFF;
            conv_sat  = 1'b1;
        end else if (r < MIN_R) begin
            conv_data = 16'h8000;
            conv_sat  = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: leave ACCUM on the last beat, leave HOLD on out_ready.
    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (accept && last) state_next = HOLD;
            HOLD:    if (out_ready) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // Handshake outputs depend on state only.
    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == HOLD);
    end

    // Element counter, accumulator and registered result.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (accept) begin
            acc <= sum;
            if (last) begin
                cnt      <= '0;
                out_data <= conv_data;
                out_sat  <= conv_sat;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule
